mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The parameters SHALL be:
- WIDTH, default 32: operand and result width, any even value 8..64.
- CNT_W, default $clog2(WIDTH)+1: iteration counter width, derived, not user-set.

REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1: single clock, rising-edge.
- reset  in  1: synchronous, active-high.
- start  in  1: request an operation.
- op  in  2: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- a  in  WIDTH: multiplicand or dividend.
- b  in  WIDTH: multiplier or divisor.
- busy  out  1: operation in progress.
- done  out  1: one-cycle completion pulse.
- hi  out  WIDTH: product upper half, or remainder.
- lo  out  WIDTH: product lower half, or quotient.
- div_zero  out  1: divide-by-zero flag, valid while done=1.

REQ-003 There SHALL be one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, MUL, DIV, FIX and DONE; every state is registered.
REQ-005 start SHALL be sampled only in IDLE; start while busy=1 or in DONE SHALL be ignored, with no queuing.
REQ-006 On an accepted start at edge T, op, |a|, |b| and the sign bits SHALL be latched; signedness is taken from op[0]=0.
REQ-007 MUL SHALL perform WIDTH shift-add iterations on magnitudes, one per cycle (T+1..T+WIDTH), giving a 2*WIDTH product.
REQ-008 DIV SHALL perform WIDTH restoring-division iterations, one per cycle (T+1..T+WIDTH).
REQ-009 FIX (T+WIDTH+1) SHALL negate the result conditionally for signed ops:
- Product negated if the operand signs differ.
- Quotient truncates toward zero.
- Remainder takes the sign of the dividend.
REQ-010 In DONE (T+WIDTH+2), the unit SHALL update hi/lo, pulse done=1 for exactly one cycle, and return to IDLE on the next edge.
REQ-011 busy SHALL be 1 in cycles T+1..T+WIDTH+1 and 0 in DONE and IDLE; a new start is accepted in the cycle after DONE.
REQ-012 DIV/DIVU with b=0 SHALL skip iteration and go to DONE at T+1 with div_zero=1; hi/lo SHALL be left unchanged.
REQ-013 div_zero SHALL be 0 on every non-faulting completion.
REQ-014 Signed DIV of the most-negative value by -1 SHALL wrap: lo=most-negative, hi=0, no flag.
REQ-015 hi/lo SHALL hold their value between completions; hi/lo SHALL never show intermediate iteration values.
REQ-016 Operand changes on a/b/op after T SHALL NOT affect the result.

Reset
REQ-017 Reset SHALL set state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0 and the counter=0.
REQ-018 Reset asserted mid-operation SHALL abort the operation at the next edge with the REQ-017 values; no done pulse is produced.
REQ-019 start asserted together with reset SHALL be ignored.

Structure
REQ-020 Package mdu_pkg SHALL hold the op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state enum.
REQ-021 Sub-module mdu_cond_neg (WIDTH-parametrised, combinational conditional two's-complement negate) SHALL be used for operand magnitude and result correction.
REQ-022 The multiplier and divider SHALL share one 2*WIDTH working register and one counter.

Verification (WIDTH=32, start accepted at edge T)
REQ-023 MULT with a=0xFFFFFFFD, b=7 -> at T+34, done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-024 MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, div_zero=0.
REQ-025 DIV with a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-026 DIVU with a=100, b=0 after a prior result -> done=1 and div_zero=1 at T+1, hi/lo equal to the prior values.
REQ-027 DIV with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-028 MULT started, then start re-pulsed at T+5 and reset at T+10:
- The T+5 pulse is ignored.
- After the T+10 reset: busy=0, hi=lo=0, no done pulse.
- A start at T+12 is accepted.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: op encoding and FSM states.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } mdu_state_e;

endpackage

// File: rtl/mdu_cond_neg.sv
// Combinational conditional two's-complement negate, used both for operand magnitudes
// and for sign correction of results.
module mdu_cond_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  always_comb begin
    res_o = val_i;
    if (neg_i) begin
      res_o = ~val_i + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiplier and restoring divider sharing one 2*WIDTH
// working register and one iteration counter.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  mdu_state_e           state_q, state_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_mul_q, is_mul_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 div_zero_q, div_zero_d;

  logic                 op_signed, op_div;
  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_rem, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic                 last_iter;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign sign_a    = op_signed & a[WIDTH-1];
  assign sign_b    = op_signed & b[WIDTH-1];

  mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_a (
    .val_i (a),
    .neg_i (sign_a),
    .res_o (mag_a)
  );

  mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_b (
    .val_i (b),
    .neg_i (sign_b),
    .res_o (mag_b)
  );

  mdu_cond_neg #(.WIDTH(2*WIDTH)) u_neg_prod (
    .val_i (work_q),
    .neg_i (neg_res_q),
    .res_o (prod_fix)
  );

  mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_quo (
    .val_i (work_q[WIDTH-1:0]),
    .neg_i (neg_res_q),
    .res_o (quo_fix)
  );

  mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_rem (
    .val_i (work_q[2*WIDTH-1:WIDTH]),
    .neg_i (neg_rem_q),
    .res_o (rem_fix)
  );

  // Shift-add: upper half accumulates the multiplicand, multiplier shifts out of the bottom.
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
                    (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  // Restoring step: upper half is the partial remainder, quotient bits enter at the bottom.
  assign div_rem  = work_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_rem - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    is_mul_d   = is_mul_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          is_mul_d  = ~op_div;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          cnt_d     = '0;
          if (!op_div) begin
            work_d  = {{WIDTH{1'b0}}, mag_b};
            opnd_d  = mag_a;
            state_d = StMul;
          end else if (b == '0) begin
            div_zero_d = 1'b1;
            state_d    = StDone;
          end else begin
            work_d  = {{WIDTH{1'b0}}, mag_a};
            opnd_d  = mag_b;
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        work_d = mul_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_iter) state_d = StFix;
      end
      StDiv: begin
        work_d = div_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_iter) state_d = StFix;
      end
      StFix: begin
        if (is_mul_q) begin
          {hi_d, lo_d} = prod_fix;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        div_zero_d = 1'b0;
        state_d    = StDone;
      end
      StDone: begin
        div_zero_d = 1'b0;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      work_q     <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      is_mul_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      is_mul_q   <= is_mul_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
  assign done     = (state_q == StDone);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule
